mul_16x8_acc: RTL

// - Sequential shift-add multiply-accumulate: result = mcand*mplier + addend.
// - Inverse of the 16/8 iterative divider; rebuilds the dividend from the divider's quotient, divisor and remainder.
// - Raises a match flag when the rebuilt dividend equals the expected value.
// - Sits downstream of the divider in the image-processing datapath as a self-check stage; also usable as a general multiplier.

---
 rtl/mul_16x8_acc_if.sv | 30 +++
 rtl/mul_16x8_acc.sv | 90 +++++++++
 2 files changed

// File: rtl/mul_16x8_acc_if.sv
// Operand/result bus between the divider self-check datapath and the MAC stage.
interface mul_16x8_acc_if #(
    parameter int unsigned QW = 16,
    parameter int unsigned DW = 8
);
    localparam int unsigned RW = QW + DW;

    logic          in_valid;
    logic          in_ready;
    logic [QW-1:0] mcand;
    logic [DW-1:0] mplier;
    logic [DW-1:0] addend;
    // 'expect' is a reserved word, so the compare operand is named 'expected'
    logic [QW-1:0] expected;
    logic [RW-1:0] result;
    logic          match;
    logic          out_valid;

    // Operand source side
    modport master (
        output in_valid, mcand, mplier, addend, expected,
        input  in_ready, result, match, out_valid
    );

    // Multiply-accumulate side
    modport slave (
        input  in_valid, mcand, mplier, addend, expected,
        output in_ready, result, match, out_valid
    );
endinterface

// File: rtl/mul_16x8_acc.sv
// Sequential shift-add multiply-accumulate (result = mcand*mplier + addend).
// Rebuilds the divider's dividend and flags whether it equals the expected value.
module mul_16x8_acc #(
    parameter int unsigned QW = 16,
    parameter int unsigned DW = 8
) (
    input  logic         clk_sys,
    input  logic         reset_sync,
    mul_16x8_acc_if.slave bus
);
    localparam int unsigned RW = QW + DW;
    localparam int unsigned CW = (DW > 1) ? $clog2(DW) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [RW-1:0] a_q;
    logic [DW-1:0] b_q;
    logic [QW-1:0] exp_q;
    logic [RW-1:0] acc_q;
    logic [CW-1:0] cnt_q;
    logic          dz_q;
    logic [RW-1:0] acc_nxt;
    logic          match_nxt;

    // Acceptance window: idle, or the single DONE cycle for back-to-back issue
    assign bus.in_ready = (state == IDLE) || (state == DONE);

    // Partial-product step and compare for the current CALC bit
    always_comb begin
        acc_nxt   = acc_q;
        if (b_q[0]) begin
            acc_nxt = acc_q + a_q;
        end
        // Divide-by-zero results are accepted regardless of the rebuilt value
        match_nxt = (acc_nxt == RW'(exp_q)) || dz_q;
    end

    // Control FSM and shift-add datapath; reset aborts any operation in flight
    always_ff @(posedge clk_sys) begin
        if (reset_sync) begin
            state         <= IDLE;
            a_q           <= '0;
            b_q           <= '0;
            exp_q         <= '0;
            acc_q         <= '0;
            cnt_q         <= '0;
            dz_q          <= 1'b0;
            bus.result    <= '0;
            bus.match     <= 1'b0;
            bus.out_valid <= 1'b0;
        end else begin
            bus.out_valid <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    if (bus.in_valid) begin
                        a_q   <= RW'(bus.mcand);
                        b_q   <= bus.mplier;
                        exp_q <= bus.expected;
                        acc_q <= RW'(bus.addend);
                        cnt_q <= '0;
                        dz_q  <= (bus.mplier == '0) && (bus.mcand == {QW{1'b1}});
                        state <= CALC;
                    end else begin
                        state <= IDLE;
                    end
                end
                CALC: begin
                    acc_q <= acc_nxt;
                    a_q   <= a_q << 1;
                    b_q   <= b_q >> 1;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(DW - 1)) begin
                        bus.result    <= acc_nxt;
                        bus.match     <= match_nxt;
                        bus.out_valid <= 1'b1;
                        state         <= DONE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
